seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
Serial pattern transmitter. Emits a programmable PAT_W-bit pattern MSB-first, one bit per clock, for a programmable number of repetitions with a programmable idle gap between repetitions. It is the stimulus/transmit end for the team's serial sequence detectors. It drives their single-bit serial input, with out_valid qualifying each bit.

Parameters:
PAT_W, 4, pattern length in bits (legal range 2..32)
DEFAULT_PAT, 4'b1010, pattern value loaded at reset
CNT_W, 8, width of repeat_n
GAP_W, 4, width of gap

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request to transmit; accepted only when ready=1
pattern  input  PAT_W  pattern to transmit, sampled on accept
repeat_n  input  CNT_W  extra repetitions; total repetitions = repeat_n+1, sampled on accept
gap  input  GAP_W  idle cycles between repetitions, sampled on accept
abort  input  1  terminate the transfer in progress
ready  output  1  high only in IDLE
busy  output  1  high in SHIFT and GAP
out  output  1  serial data; 0 whenever out_valid=0
out_valid  output  1  out carries a pattern bit this cycle
frame_start  output  1  high on the first (MSB) bit of each repetition
done  output  1  one-cycle pulse after the final bit of a completed transfer

Behaviour:
- All outputs are registered (Moore).
- Reset values (asynchronous, reset=0): state IDLE, ready=1, busy=0, out=0, out_valid=0, frame_start=0, done=0, shift register=DEFAULT_PAT, all counters 0.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 at clock edge k captures pattern, repeat_n and gap, then moves to SHIFT.
  - Cycle k+1: out=pattern[PAT_W-1], out_valid=1, frame_start=1.
  - Latency from accept to first bit is 1 cycle.
  - abort is ignored in IDLE.
- SHIFT:
  - One bit per cycle, MSB first; bit_cnt counts PAT_W-1 down to 0.
  - After the LSB with repetitions remaining:
    - gap>0: go to GAP.
    - gap=0: go directly to SHIFT with the MSB, back-to-back with no bubble; frame_start=1 on that cycle.
  - After the LSB of the final repetition: go to DONE.
- GAP:
  - Lasts exactly gap cycles, with out=0 and out_valid=0.
  - Then returns to SHIFT with the MSB and frame_start=1.
- DONE:
  - One cycle with done=1, ready=0, busy=0, then IDLE.
  - start during DONE is ignored.
- Accept-to-done cycle count: (repeat_n+1)*PAT_W + repeat_n*gap bit/gap cycles, then the DONE cycle.
- abort=1 in SHIFT or GAP:
  - Next cycle is IDLE: out_valid=0, out=0, no done pulse, ready=1.
  - The bit on the abort cycle itself is still valid.
- start while busy=1 is ignored. Inputs are not re-sampled mid-transfer.
- rep_cnt counts down from repeat_n, so repeat_n = 2^CNT_W-1 gives 2^CNT_W repetitions with no overflow.
- bit_cnt width is clog2(PAT_W).
- Reset asserted mid-transfer forces the reset values immediately, without waiting for a clock edge. Deassertion resumes in IDLE.

Decomposition:
- Package seq_tx_pkg holds:
  - state encoding constants S_IDLE=2'b00, S_SHIFT=2'b01, S_GAP=2'b10, S_DONE=2'b11;
  - a clog2 function for the counter widths.
- Natural sub-module: pat_piso, a PAT_W-bit parallel-load, shift-left register.
  - Ports: load, shift, load value, MSB out.
  - Same clk and async active-low reset.
- FSM and counters stay in seq_pattern_tx.

Test Plan:
1. Reset, then start with pattern=4'b1010, repeat_n=0, gap=0 -> out=1,0,1,0 with out_valid=1 on 4 consecutive cycles starting 1 cycle after accept; frame_start on the first bit only; done=1 the next cycle; ready=1 the cycle after.
2. pattern=1010, repeat_n=2, gap=0 -> 12 contiguous valid bits 101010101010; frame_start on bits 0, 4 and 8; exactly one done pulse, 13 cycles after accept.
3. pattern=4'b1100, repeat_n=1, gap=3 -> valid 1100, then 3 cycles out_valid=0/out=0, then valid 1100, then done; 11 cycles from first bit to last bit.
4. abort asserted on the 2nd bit of the first repetition (repeat_n=3) -> out_valid=0 and ready=1 on the next cycle; done never pulses; a new start is accepted immediately afterwards.
5. reset driven low between clock edges mid-SHIFT -> all outputs take their reset values before the next rising edge; after release, ready=1 and out_valid=0.
6. start held high through busy and DONE -> no re-accept until IDLE; the transfer restarts on the first IDLE cycle with freshly sampled inputs (pattern=4'b0110 -> 0,1,1,0).

Source files
------------

// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   state_e : FSM state encoding (also exported on the debug state port)
//   clog2   : ceiling log2 used to size the bit counter (minimum 1 bit)
package seq_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_GAP   = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/pat_piso.sv
// Parallel-load, shift-left register holding the pattern being sent.
// The bit currently on the line is always the MSB.
//   clk, reset : clock and asynchronous active-low reset
//   load       : capture load_val (takes priority over shift)
//   shift      : shift left by one, zero fill
//   load_val   : parallel load value
//   msb        : current MSB
module pat_piso #(
    parameter int                PAT_W       = 4,
    parameter logic [PAT_W-1:0]  DEFAULT_PAT = 4'b1010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] load_val,
    output logic             msb
);

    logic [PAT_W-1:0] data_q;
    logic [PAT_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_val;
        end else if (shift) begin
            data_d = {data_q[PAT_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= DEFAULT_PAT;
        end else begin
            data_q <= data_d;
        end
    end

    assign msb = data_q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a PAT_W-bit pattern MSB-first, one bit
// per clock, repeat_n+1 times with gap idle cycles between repetitions.
//   clk, reset   : clock and asynchronous active-low reset
//   start        : transfer request, accepted only while ready=1
//   pattern, repeat_n, gap : transfer parameters, sampled on accept
//   abort        : end the transfer in progress (ignored in IDLE)
//   ready / busy : IDLE / (SHIFT or GAP) indicators
//   out, out_valid, frame_start : serial bit, its qualifier, first-bit marker
//   done         : one-cycle pulse after the last bit of a completed transfer
//   state_dbg    : current FSM state
// Handshake: a transfer is accepted on a rising edge where start=1 and
// ready=1; start at any other time has no effect.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1010,
    parameter int               CNT_W       = 8,
    parameter int               GAP_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam int               BIT_W    = clog2(PAT_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

    state_e           state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [GAP_W-1:0] gap_val_q, gap_val_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             done_q, done_d;

    logic             piso_load;
    logic             piso_shift;
    logic [PAT_W-1:0] piso_val;
    logic             piso_msb;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rep_cnt_d     = rep_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        gap_val_d     = gap_val_q;
        pat_d         = pat_q;
        ready_d       = 1'b0;
        busy_d        = 1'b0;
        out_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        done_d        = 1'b0;
        piso_load     = 1'b0;
        piso_shift    = 1'b0;
        piso_val      = pat_q;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (start) begin
                    pat_d         = pattern;
                    rep_cnt_d     = repeat_n;
                    gap_val_d     = gap;
                    bit_cnt_d     = BIT_LAST;
                    piso_load     = 1'b1;
                    piso_val      = pattern;
                    state_d       = S_SHIFT;
                    ready_d       = 1'b0;
                    busy_d        = 1'b1;
                    out_valid_d   = 1'b1;
                    frame_start_d = 1'b1;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else if (bit_cnt_q != '0) begin
                    piso_shift  = 1'b1;
                    bit_cnt_d   = bit_cnt_q - BIT_W'(1);
                    busy_d      = 1'b1;
                    out_valid_d = 1'b1;
                end else if (rep_cnt_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (gap_val_q == '0) begin
                    // Back-to-back repetition: reload with no idle bubble.
                    piso_load     = 1'b1;
                    bit_cnt_d     = BIT_LAST;
                    rep_cnt_d     = rep_cnt_q - CNT_W'(1);
                    busy_d        = 1'b1;
                    out_valid_d   = 1'b1;
                    frame_start_d = 1'b1;
                end else begin
                    state_d   = S_GAP;
                    gap_cnt_d = gap_val_q;
                    rep_cnt_d = rep_cnt_q - CNT_W'(1);
                    busy_d    = 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    // Last idle cycle: the next cycle carries the MSB.
                    piso_load     = 1'b1;
                    bit_cnt_d     = BIT_LAST;
                    state_d       = S_SHIFT;
                    busy_d        = 1'b1;
                    out_valid_d   = 1'b1;
                    frame_start_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    busy_d    = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            rep_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            gap_val_q     <= '0;
            pat_q         <= DEFAULT_PAT;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rep_cnt_q     <= rep_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            gap_val_q     <= gap_val_d;
            pat_q         <= pat_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
        end
    end

    pat_piso #(
        .PAT_W       (PAT_W),
        .DEFAULT_PAT (DEFAULT_PAT)
    ) u_piso (
        .clk      (clk),
        .reset    (reset),
        .load     (piso_load),
        .shift    (piso_shift),
        .load_val (piso_val),
        .msb      (piso_msb)
    );

    // The shift register always holds a value, so the line is forced low
    // whenever no bit is being qualified.
    assign out         = piso_msb & out_valid_q;
    assign ready       = ready_q;
    assign busy        = busy_q;
    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign done        = done_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
module tb_seq_pattern_tx;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [CNT_W-1:0] repeat_n = '0;
    logic [GAP_W-1:0] gap = '0;
    logic             abort = 1'b0;
    logic             ready, busy, out, out_valid, frame_start, done;
    logic [1:0]       state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int xfer_id  = 0;

    // Observed cycle: {ready, busy, out_valid, out, frame_start, done}
    logic [5:0] obs;
    assign obs = {ready, busy, out_valid, out, frame_start, done};

    localparam logic [5:0] IDLE_V = 6'b100000;
    localparam logic [5:0] GAP_V  = 6'b010000;
    localparam logic [5:0] DONE_V = 6'b000001;

    logic [5:0] exp_q[$];

    seq_pattern_tx #(
        .PAT_W       (PAT_W),
        .DEFAULT_PAT (4'b1010),
        .CNT_W       (CNT_W),
        .GAP_W       (GAP_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pattern     (pattern),
        .repeat_n    (repeat_n),
        .gap         (gap),
        .abort       (abort),
        .ready       (ready),
        .busy        (busy),
        .out         (out),
        .out_valid   (out_valid),
        .frame_start (frame_start),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference trace: one entry per cycle after the accept edge.
    task automatic build_trace(input logic [PAT_W-1:0] pat, input int rep, input int gp,
                               input int abort_at);
        exp_q.delete();
        for (int r = 0; r <= rep; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--) begin
                exp_q.push_back({1'b0, 1'b1, 1'b1, pat[b], (b == PAT_W - 1), 1'b0});
            end
            if (r < rep) begin
                for (int g = 0; g < gp; g++) exp_q.push_back(GAP_V);
            end
        end
        if (abort_at >= 0 && abort_at < exp_q.size()) begin
            while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
        end else begin
            exp_q.push_back(DONE_V);
        end
        exp_q.push_back(IDLE_V);
    endtask

    // driver: called at posedge+1 with the DUT in IDLE; returns at posedge+1
    // on the first IDLE cycle after the transfer.
    task automatic run_xfer(input logic [PAT_W-1:0] pat, input int rep, input int gp,
                            input int abort_at, input bit hold, input logic [PAT_W-1:0] next_pat);
        int idx;
        logic [5:0] e;
        xfer_id++;
        start    = 1'b1;
        pattern  = pat;
        repeat_n = CNT_W'(rep);
        gap      = GAP_W'(gp);
        build_trace(pat, rep, gp, abort_at);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            start = hold;
            if (hold) begin
                pattern  = next_pat;
                repeat_n = CNT_W'(rep + 1);
                gap      = GAP_W'(gp + 1);
            end
            e = exp_q.pop_front();
            check($sformatf("xfer%0d_cyc%0d", xfer_id, idx), {26'd0, obs}, {26'd0, e});
            abort = (idx == abort_at);
            idx++;
        end
        abort = 1'b0;
    endtask

    initial begin
        int rep, gp, len, ab;
        logic [PAT_W-1:0] pat;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {26'd0, obs}, {26'd0, IDLE_V});
        check("reset_state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", {26'd0, obs}, {26'd0, IDLE_V});

        // single repetition, no gap
        run_xfer(4'b1010, 0, 0, -1, 1'b0, '0);
        // three back-to-back repetitions
        run_xfer(4'b1010, 2, 0, -1, 1'b0, '0);
        // two repetitions separated by a 3-cycle gap
        run_xfer(4'b1100, 1, 3, -1, 1'b0, '0);
        // abort on the second bit, then an immediate new transfer
        run_xfer(4'b1011, 3, 2, 1, 1'b0, '0);
        run_xfer(4'b0111, 0, 0, -1, 1'b0, '0);
        // abort during a gap and on the final bit
        run_xfer(4'b1001, 1, 4, 5, 1'b0, '0);
        run_xfer(4'b1110, 1, 1, 8, 1'b0, '0);
        // maximum gap
        run_xfer(4'b0101, 1, 15, -1, 1'b0, '0);
        // start held through busy and DONE with changing inputs
        run_xfer(4'b1010, 1, 2, -1, 1'b1, 4'b0110);
        run_xfer(4'b0110, 0, 0, -1, 1'b0, '0);
        // maximum repeat count: 256 repetitions
        run_xfer(4'b1101, 255, 0, -1, 1'b0, '0);

        // asynchronous reset mid-SHIFT
        start    = 1'b1;
        pattern  = 4'b1010;
        repeat_n = 8'd2;
        gap      = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("pre_reset_bit0", {26'd0, obs}, {26'd0, 6'b011110});
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {26'd0, obs}, {26'd0, IDLE_V});
        check("async_reset_state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("after_async_reset", {26'd0, obs}, {26'd0, IDLE_V});

        // randomized transfers
        for (int t = 0; t < 30; t++) begin
            pat = PAT_W'($urandom_range(0, 15));
            rep = $urandom_range(0, 3);
            gp  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            len = (rep + 1) * PAT_W + rep * gp;
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            run_xfer(pat, rep, gp, ab, 1'b0, '0);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                check("idle_hold", {26'd0, obs}, {26'd0, IDLE_V});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
